// File: rtl/icache_core_if.sv
// Fetch-side request/response and refill burst-bus signals of icache_core.
// The cache itself uses the slave modport; fetch stage and memory bus use master.
interface icache_core_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        icache_ready;
  logic        resp_rdy;
  logic        flush;
  logic [31:0] icache_data;
  logic        icache_data_valid;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  modport slave (
    input  req_valid, req_addr, resp_rdy, flush, rd_rdy, ret_valid, ret_last, ret_data,
    output icache_ready, icache_data, icache_data_valid, rd_req, rd_addr, hit_cnt, miss_cnt
  );

  modport master (
    output req_valid, req_addr, resp_rdy, flush, rd_rdy, ret_valid, ret_last, ret_data,
    input  icache_ready, icache_data, icache_data_valid, rd_req, rd_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_core.sv
// Direct-mapped read-only instruction cache with burst line refill.
// Define ICACHE_PERF_CNT_EN to build the hit/miss performance counters.
module icache_core #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 64
) (
  input  logic         clk,
  input  logic         rst,
  icache_core_if.slave bus
);
  localparam int unsigned OFFS_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W   = $clog2(SETS);
  localparam int unsigned LSB_IDX = 2 + OFFS_W;
  localparam int unsigned LSB_TAG = LSB_IDX + IDX_W;
  localparam int unsigned TAG_W   = 32 - LSB_TAG;

  typedef enum logic [1:0] {IDLE, MISS, REFILL, RESP} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]   line_valid_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [31:0]       data_mem [SETS*LINE_WORDS];

  logic              s2_valid_q, s2_valid_d;
  logic [31:2]       s2_addr_q;
  logic              s2_hit_q;
  logic [31:0]       resp_word_q;
  logic [OFFS_W-1:0] beat_q;
  logic              cancel_q, cancel_d;

  logic              accept, refill_start, beat_we, line_done, hit_deliver;
  logic              ready_c, data_valid_c, rd_req_c;

  logic [IDX_W-1:0]  req_idx, s2_idx;
  logic [TAG_W-1:0]  req_tag, s2_tag;
  logic [OFFS_W-1:0] req_off, s2_off;
  logic              unused_addr_bits;

  assign req_idx = bus.req_addr[LSB_TAG-1:LSB_IDX];
  assign req_tag = bus.req_addr[31:LSB_TAG];
  assign req_off = bus.req_addr[LSB_IDX-1:2];
  assign s2_idx  = s2_addr_q[LSB_TAG-1:LSB_IDX];
  assign s2_tag  = s2_addr_q[31:LSB_TAG];
  assign s2_off  = s2_addr_q[LSB_IDX-1:2];
  assign unused_addr_bits = ^bus.req_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshakes and datapath enables.
  always_comb begin
    state_d      = state_q;
    s2_valid_d   = s2_valid_q;
    cancel_d     = cancel_q;
    accept       = 1'b0;
    refill_start = 1'b0;
    beat_we      = 1'b0;
    line_done    = 1'b0;
    hit_deliver  = 1'b0;
    ready_c      = 1'b0;
    data_valid_c = 1'b0;
    rd_req_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_c      = ~bus.flush & (~s2_valid_q | (s2_hit_q & bus.resp_rdy));
        data_valid_c = s2_valid_q & s2_hit_q;
        hit_deliver  = data_valid_c & bus.resp_rdy;
        accept       = ready_c & bus.req_valid;
        if (accept)                         s2_valid_d = 1'b1;
        else if (bus.flush || hit_deliver)  s2_valid_d = 1'b0;
        else if (s2_valid_q && !s2_hit_q)   state_d    = MISS;
      end
      MISS: begin
        rd_req_c = 1'b1;
        if (bus.rd_rdy) begin
          // A flush racing the accepted handshake still lets the burst run.
          state_d      = REFILL;
          refill_start = 1'b1;
          cancel_d     = bus.flush;
        end else if (bus.flush) begin
          state_d    = IDLE;
          s2_valid_d = 1'b0;
        end
      end
      REFILL: begin
        if (bus.flush) cancel_d = 1'b1;
        if (bus.ret_valid) begin
          beat_we = 1'b1;
          if (bus.ret_last) begin
            line_done = 1'b1;
            if (cancel_q || bus.flush) begin
              state_d    = IDLE;
              s2_valid_d = 1'b0;
            end else begin
              state_d = RESP;
            end
          end
        end
      end
      RESP: begin
        data_valid_c = 1'b1;
        if (bus.flush || bus.resp_rdy) begin
          state_d    = IDLE;
          s2_valid_d = 1'b0;
        end
      end
    endcase
  end

  // Lookup stage, refill beat counter and line valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q   <= 1'b0;
      s2_addr_q    <= '0;
      s2_hit_q     <= 1'b0;
      resp_word_q  <= '0;
      beat_q       <= '0;
      cancel_q     <= 1'b0;
      line_valid_q <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      cancel_q   <= cancel_d;
      if (accept) begin
        s2_addr_q   <= bus.req_addr[31:2];
        s2_hit_q    <= line_valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
        resp_word_q <= data_mem[{req_idx, req_off}];
      end
      if (refill_start) begin
        beat_q <= '0;
      end else if (beat_we) begin
        beat_q <= beat_q + OFFS_W'(1);
        if (beat_q == s2_off) resp_word_q <= bus.ret_data;
      end
      if (line_done) line_valid_q[s2_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; line_valid_q qualifies them.
  always_ff @(posedge clk) begin
    if (beat_we)   data_mem[{s2_idx, beat_q}] <= bus.ret_data;
    if (line_done) tag_mem[s2_idx]            <= s2_tag;
  end

  assign bus.icache_ready      = ready_c;
  assign bus.icache_data_valid = data_valid_c;
  assign bus.icache_data       = resp_word_q;
  assign bus.rd_req            = rd_req_c;
  assign bus.rd_addr           = {s2_addr_q[31:LSB_IDX], {LSB_IDX{1'b0}}};

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_deliver)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (refill_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif

  // A short burst would leave stale words in the line.
  assert property (@(posedge clk) disable iff (rst)
    (state_q == REFILL && bus.ret_valid && bus.ret_last) |-> (beat_q == OFFS_W'(LINE_WORDS - 1)));

endmodule
